// File: rtl/mips_cpu_fetch.sv
// Instruction-fetch responder: turns a PC into one Avalon-MM read and returns the word,
// pulsing the PC register's enable on completion and flagging misaligned or timed-out fetches.
module mips_cpu_fetch #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter bit SWAP_BYTES     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fetch_req,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        pc_enable,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int WCW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t         state_q, state_d;
    logic [31:0]    avm_address_q, avm_address_d;
    logic           avm_read_q, avm_read_d;
    logic [3:0]     avm_byteenable_q, avm_byteenable_d;
    logic [31:0]    instr_q, instr_d;
    logic           instr_valid_q, instr_valid_d;
    logic           pc_enable_q, pc_enable_d;
    logic           fault_q, fault_d;
    logic [1:0]     fault_code_q, fault_code_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           flush_pending_q, flush_pending_d;
    logic [31:0]    read_word;

    // MIPS expects big-endian byte order; the bus delivers little-endian lanes
    assign read_word = SWAP_BYTES ? {avm_readdata[7:0], avm_readdata[15:8],
                                     avm_readdata[23:16], avm_readdata[31:24]}
                                  : avm_readdata;

    always_comb begin
        state_d         = state_q;
        avm_address_d   = avm_address_q;
        avm_read_d      = avm_read_q;
        instr_d         = instr_q;
        instr_valid_d   = 1'b0;
        pc_enable_d     = 1'b0;
        fault_d         = fault_q;
        fault_code_d    = fault_code_q;
        wait_cnt_d      = wait_cnt_q;
        flush_pending_d = flush_pending_q;

        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    if (pc[1:0] == 2'b00) begin
                        avm_address_d   = {pc[31:2], 2'b00};
                        avm_read_d      = 1'b1;
                        wait_cnt_d      = '0;
                        flush_pending_d = 1'b0;
                        state_d         = REQ;
                    end else begin
                        fault_d      = 1'b1;
                        fault_code_d = 2'b01;
                        state_d      = ERR;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (!avm_waitrequest) begin
                    avm_read_d = 1'b0;
                    // A redirected fetch still finishes on the bus but its data is dropped
                    if (flush_pending_q || flush) begin
                        flush_pending_d = 1'b0;
                        state_d         = IDLE;
                    end else begin
                        instr_d = read_word;
                        state_d = DONE;
                    end
                end else begin
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_q == WAIT_LAST) begin
                        avm_read_d   = 1'b0;
                        fault_d      = 1'b1;
                        fault_code_d = 2'b10;
                        state_d      = ERR;
                    end
                end
            end
            DONE: begin
                instr_valid_d   = 1'b1;
                pc_enable_d     = 1'b1;
                flush_pending_d = 1'b0;
                state_d         = IDLE;
            end
            ERR: begin
                avm_read_d = 1'b0;
                fault_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        avm_byteenable_d = avm_read_d ? 4'b1111 : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            avm_address_q    <= '0;
            avm_read_q       <= 1'b0;
            avm_byteenable_q <= 4'b0000;
            instr_q          <= '0;
            instr_valid_q    <= 1'b0;
            pc_enable_q      <= 1'b0;
            fault_q          <= 1'b0;
            fault_code_q     <= 2'b00;
            wait_cnt_q       <= '0;
            flush_pending_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            avm_address_q    <= avm_address_d;
            avm_read_q       <= avm_read_d;
            avm_byteenable_q <= avm_byteenable_d;
            instr_q          <= instr_d;
            instr_valid_q    <= instr_valid_d;
            pc_enable_q      <= pc_enable_d;
            fault_q          <= fault_d;
            fault_code_q     <= fault_code_d;
            wait_cnt_q       <= wait_cnt_d;
            flush_pending_q  <= flush_pending_d;
        end
    end

    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_byteenable = avm_byteenable_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign pc_enable      = pc_enable_q;
    assign fault          = fault_q;
    assign fault_code     = fault_code_q;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Self-checking bench for mips_cpu_fetch: a byte-swapping instance with a short timeout and a
// pass-through instance share all stimulus; valid instructions are checked through a scoreboard.
module tb_mips_cpu_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_req;
    logic        flush;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    logic [31:0] instr, avm_address;
    logic        instr_valid, pc_enable, avm_read, fault;
    logic [3:0]  avm_byteenable;
    logic [1:0]  fault_code;

    logic [31:0] ns_instr, ns_avm_address;
    logic        ns_instr_valid, ns_pc_enable, ns_avm_read, ns_fault;
    logic [3:0]  ns_avm_byteenable;
    logic [1:0]  ns_fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        int          waits;
        int          flush_at;
        bit          flushed;
        logic [31:0] exp_instr;
        logic [31:0] exp_instr_ns;
    } vec_t;

    vec_t vecs[5];

    mips_cpu_fetch #(.TIMEOUT_CYCLES(4), .SWAP_BYTES(1'b1)) dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req), .flush(flush),
        .instr(instr), .instr_valid(instr_valid), .pc_enable(pc_enable),
        .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .fault(fault), .fault_code(fault_code)
    );

    mips_cpu_fetch #(.TIMEOUT_CYCLES(1024), .SWAP_BYTES(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req), .flush(flush),
        .instr(ns_instr), .instr_valid(ns_instr_valid), .pc_enable(ns_pc_enable),
        .avm_address(ns_avm_address), .avm_read(ns_avm_read), .avm_byteenable(ns_avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .fault(ns_fault), .fault_code(ns_fault_code)
    );

    // 10 ns clock; stimulus changes 1 ns after each rising edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset           = 1'b0;
        fetch_req       = 1'b0;
        flush           = 1'b0;
        avm_waitrequest = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Every instr_valid/pc_enable pulse must be simultaneous and match the oldest queued word
    always @(negedge clk) begin
        if (reset && (instr_valid || pc_enable)) begin
            checkOutput("pc_enable_with_valid", {31'b0, pc_enable}, {31'b0, instr_valid});
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                checkOutput("scoreboard_instr", instr, exp_q.pop_front());
            end
        end
    end

    // One full fetch: request, optional wait states and flush, then the valid pulse window
    task automatic applyStimulus(input vec_t v);
        pc           = v.pc;
        avm_readdata = v.rdata;
        fetch_req    = 1'b1;
        if (!v.flushed) exp_q.push_back(v.exp_instr);
        step();
        fetch_req = 1'b0;
        for (int w = 0; w <= v.waits; w++) begin
            avm_waitrequest = (w < v.waits);
            flush           = (w == v.flush_at);
            checkOutput("avm_read_held", {31'b0, avm_read}, 32'd1);
            checkOutput("avm_address", avm_address, {v.pc[31:2], 2'b00});
            checkOutput("avm_byteenable", {28'b0, avm_byteenable}, 32'hF);
            step();
        end
        avm_waitrequest = 1'b0;
        flush           = 1'b0;
        checkOutput("avm_read_dropped", {31'b0, avm_read}, 32'd0);
        checkOutput("avm_byteenable_idle", {28'b0, avm_byteenable}, 32'h0);
        step();
        checkOutput("instr_valid_latency", {31'b0, instr_valid}, {31'b0, !v.flushed});
        checkOutput("instr", instr, v.exp_instr);
        checkOutput("instr_noswap", ns_instr, v.exp_instr_ns);
        step();
        checkOutput("instr_valid_one_cycle", {31'b0, instr_valid}, 32'd0);
        checkOutput("pc_enable_one_cycle", {31'b0, pc_enable}, 32'd0);
    endtask

    initial begin
        int   rd_cnt;
        bit   pe_seen;
        bit   rd_seen;
        vec_t fresh;

        vecs[0] = '{32'hBFC00000, 32'h78563412, 0, -1, 1'b0, 32'h12345678, 32'h78563412};
        vecs[1] = '{32'hBFC00004, 32'h78563412, 3, -1, 1'b0, 32'h12345678, 32'h78563412};
        vecs[2] = '{32'hBFC00008, 32'hDEADBEEF, 2,  1, 1'b1, 32'h12345678, 32'h78563412};
        vecs[3] = '{32'hBFC0000C, 32'h04030201, 1, -1, 1'b0, 32'h01020304, 32'h04030201};
        vecs[4] = '{32'h00000010, 32'hAABBCCDD, 0, -1, 1'b0, 32'hDDCCBBAA, 32'hAABBCCDD};

        pc           = 32'h0;
        avm_readdata = 32'h0;
        doReset();

        checkOutput("reset_avm_read", {31'b0, avm_read}, 32'd0);
        checkOutput("reset_avm_address", avm_address, 32'd0);
        checkOutput("reset_byteenable", {28'b0, avm_byteenable}, 32'd0);
        checkOutput("reset_instr", instr, 32'd0);
        checkOutput("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("reset_pc_enable", {31'b0, pc_enable}, 32'd0);
        checkOutput("reset_fault", {31'b0, fault}, 32'd0);
        checkOutput("reset_fault_code", {30'b0, fault_code}, 32'd0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset while a read is stalled: the bus strobe must drop and state clear
        pc              = 32'hBFC00020;
        avm_waitrequest = 1'b1;
        fetch_req       = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        checkOutput("midread_avm_read", {31'b0, avm_read}, 32'd1);
        reset = 1'b0;
        step();
        checkOutput("midreset_avm_read", {31'b0, avm_read}, 32'd0);
        checkOutput("midreset_address", avm_address, 32'd0);
        checkOutput("midreset_instr", instr, 32'd0);
        checkOutput("midreset_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("midreset_fault", {31'b0, fault}, 32'd0);
        reset           = 1'b1;
        avm_waitrequest = 1'b0;
        fresh = '{32'hBFC00000, 32'h78563412, 0, -1, 1'b0, 32'h12345678, 32'h78563412};
        applyStimulus(fresh);

        // Slave stuck in wait: strobe held exactly TIMEOUT_CYCLES cycles, then bus-timeout fault
        pc              = 32'hBFC00040;
        avm_waitrequest = 1'b1;
        fetch_req       = 1'b1;
        step();
        fetch_req = 1'b0;
        rd_cnt    = 0;
        pe_seen   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (avm_read) rd_cnt++;
            if (pc_enable) pe_seen = 1'b1;
            step();
        end
        checkOutput("timeout_read_cycles", rd_cnt, 32'd4);
        checkOutput("timeout_no_pc_enable", {31'b0, pe_seen}, 32'd0);
        checkOutput("timeout_fault", {31'b0, fault}, 32'd1);
        checkOutput("timeout_fault_code", {30'b0, fault_code}, 32'd2);
        checkOutput("timeout_noswap_still_reading", {31'b0, ns_avm_read}, 32'd1);
        doReset();

        // Misaligned PC: no bus cycle, fault sticks through later requests until reset
        pc        = 32'hBFC00002;
        fetch_req = 1'b1;
        step();
        checkOutput("misalign_fault", {31'b0, fault}, 32'd1);
        checkOutput("misalign_fault_code", {30'b0, fault_code}, 32'd1);
        pc      = 32'hBFC00000;
        rd_seen = avm_read;
        for (int i = 0; i < 4; i++) begin
            step();
            if (avm_read) rd_seen = 1'b1;
        end
        fetch_req = 1'b0;
        checkOutput("misalign_no_read", {31'b0, rd_seen}, 32'd0);
        checkOutput("misalign_sticky_code", {30'b0, fault_code}, 32'd1);
        checkOutput("misalign_sticky_fault", {31'b0, fault}, 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        checkOutput("fault_cleared", {31'b0, fault}, 32'd0);
        checkOutput("fault_code_cleared", {30'b0, fault_code}, 32'd0);

        step();
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_fetch.md
Name: mips_cpu_fetch

Overview:
Instruction-fetch responder on the far side of the program-counter interface. Takes the current PC, performs one Avalon-MM read per instruction on the shared memory bus, and returns the fetched word. It also drives the PC register's clock enable, so the PC advances only when a fetch completes. It sits between the PC register and the bus master port, and reports misaligned-PC and bus-timeout faults.

Parameters:
TIMEOUT_CYCLES, 1024, maximum consecutive waitrequest cycles tolerated before a timeout fault; must be ≥ 2.
SWAP_BYTES, 1, 1 = byte-reverse readdata into big-endian MIPS order; 0 = pass through unchanged.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
pc  input  32  current PC from the PC register.
fetch_req  input  1  request to fetch the instruction at pc; sampled only in IDLE.
flush  input  1  discard the in-flight fetch (branch redirect).
instr  output  32  last fetched instruction; holds its value between fetches.
instr_valid  output  1  one-cycle pulse when instr is newly updated.
pc_enable  output  1  clock enable to the PC register; one-cycle pulse, coincident with instr_valid.
avm_address  output  32  word-aligned bus address.
avm_read  output  1  bus read strobe.
avm_byteenable  output  4  always 4'b1111 while avm_read==1, else 4'b0000.
avm_waitrequest  input  1  slave stall.
avm_readdata  input  32  read data; valid in the cycle avm_read==1 && avm_waitrequest==0.
fault  output  1  sticky fault flag.
fault_code  output  2  01 = misaligned PC, 10 = bus timeout, 00 = none.

Behaviour:
- Reset values: state IDLE; avm_read 0; avm_address 0; avm_byteenable 0; instr 0; instr_valid 0; pc_enable 0; fault 0; fault_code 00; wait counter 0; flush_pending 0.
- FSM states: IDLE, REQ, DONE, ERR. All outputs are registered.
- IDLE:
  - fetch_req==1 && pc[1:0]==00: latch avm_address={pc[31:2],2'b00}, set avm_read=1, clear wait counter, go to REQ.
  - fetch_req==1 && pc[1:0]!=00: go to ERR with fault_code=01; no bus cycle is issued.
  - fetch_req==0: stay in IDLE.
- REQ:
  - avm_read, avm_address and avm_byteenable are held stable until the slave accepts.
  - Edge with avm_waitrequest==0: capture avm_readdata (bytes [7:0],[15:8],[23:16],[31:24] reversed if SWAP_BYTES==1); drop avm_read; go to DONE.
  - Edge with avm_waitrequest==1: increment the wait counter. If the counter already equals TIMEOUT_CYCLES-1, drop avm_read and go to ERR with fault_code=10.
  - flush==1 at any edge in REQ sets flush_pending. The bus read still completes (no Avalon cancel), but the captured data is discarded: instr is unchanged, and the block returns to IDLE with no instr_valid or pc_enable pulse.
- DONE: instr_valid=1 and pc_enable=1 for exactly one cycle; clear flush_pending; go to IDLE. flush asserted in DONE has no effect.
- Latency: with no wait states, fetch_req at edge N gives avm_read high after N, data captured at N+1, and instr_valid/pc_enable high after N+2. Each wait cycle adds one cycle.
- fetch_req outside IDLE is ignored (no queuing).
- ERR: sticky. avm_read=0, pc_enable=0, instr_valid=0, fault=1, fault_code held. Only reset exits ERR.
- Reset mid-transaction: avm_read is low after the resetting edge; any pending data is discarded.
- Wait counter width is clog2(TIMEOUT_CYCLES); it saturates and never wraps.

Test Plan:
- Zero-wait fetch: reset, pc=32'hBFC00000, fetch_req=1 one cycle, waitrequest=0, readdata=32'h78563412 -> avm_address=32'hBFC00000 and avm_read high for exactly 1 cycle; instr=32'h12345678 with instr_valid and pc_enable high one cycle, 2 cycles after the request edge.
- Wait states: same request with waitrequest high for 3 cycles -> avm_read/avm_address stable 4 cycles; instr_valid 3 cycles later than the zero-wait case; SWAP_BYTES=0 gives instr=32'h78563412.
- Misaligned PC: pc=32'hBFC00002, fetch_req=1 -> avm_read never asserts; fault=1, fault_code=01 next cycle; held through further fetch_req until reset==0.
- Timeout: TIMEOUT_CYCLES=4, waitrequest stuck high -> avm_read drops after 4 cycles; fault_code=10; pc_enable never pulses.
- Flush: flush pulses during a 2-wait-cycle read with readdata=32'hDEADBEEF -> read completes; instr keeps its previous value; no instr_valid or pc_enable; next fetch_req is accepted normally.
- Reset mid-read: reset==0 while in REQ with waitrequest high -> avm_read=0, all outputs at reset values the following cycle; a new fetch succeeds afterwards.
